// File: rtl/vadd_pkg.sv
// Shared types and helpers for the vector-add sequencer.
package vadd_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed overflow from operand/result sign bits; independent of data width.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/vadd_seq_if.sv
// Host control and RAM port bundle of the vector-add sequencer.
interface vadd_seq_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              host_gnt;
  logic              ra_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_dout;
  logic              rb_en;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_dout;
  logic              ws_en;
  logic [ADDR_W-1:0] ws_addr;
  logic [DATA_W-1:0] ws_din;
  logic              ovf;

  modport master (
    input  start, len, abort, ra_dout, rb_dout,
    output busy, done, host_gnt, ra_en, ra_addr, rb_en, rb_addr,
           ws_en, ws_addr, ws_din, ovf
  );

  modport slave (
    output start, len, abort, ra_dout, rb_dout,
    input  busy, done, host_gnt, ra_en, ra_addr, rb_en, rb_addr,
           ws_en, ws_addr, ws_din, ovf
  );
endinterface

// File: rtl/vadd_add_stage.sv
// Registered signed add with overflow flag; saturates when VADD_SAT_EN is defined.
module vadd_add_stage
  import vadd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] res_c;
  logic              ovf_c;

  always_comb begin
    raw_c = a + b;
    ovf_c = add_ovf(a[DATA_W-1], b[DATA_W-1], raw_c[DATA_W-1]);
    res_c = raw_c;
`ifdef VADD_SAT_EN
    // Both operands share a sign on overflow, so that sign picks the rail.
    if (ovf_c) res_c = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      sum <= res_c;
      ovf <= ovf_c;
    end
  end

endmodule

// File: rtl/vadd_seq.sv
// Vector-add sequencer: streams A/B reads, adds, writes S with 2-cycle issue-to-write latency.
// Build option: VADD_SAT_EN selects saturating sums instead of wrapping.
module vadd_seq
  import vadd_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic        clk,
  input logic        rst_n,
  vadd_seq_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt, cnt, cnt_nxt;
  logic              ra_en, ra_en_nxt;
  logic [ADDR_W-1:0] ra_addr, ra_addr_nxt;
  logic              v1, v2;
  logic [ADDR_W-1:0] a1, a2;
  logic              busy_q, done_q, gnt_q, ovf_q, ovf_nxt;
  logic [DATA_W-1:0] sum;
  logic              sum_ovf;
  logic              kill_c;

  vadd_add_stage #(.DATA_W(DATA_W)) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.ra_dout),
    .b     (bus.rb_dout),
    .sum   (sum),
    .ovf   (sum_ovf)
  );

  assign kill_c = (state != IDLE) && bus.abort;

  // Next state, read issue and sticky overflow
  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    cnt_nxt     = cnt;
    ra_en_nxt   = 1'b0;
    ra_addr_nxt = ra_addr;
    ovf_nxt     = ovf_q | (v2 & sum_ovf);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          ovf_nxt = 1'b0;
          len_nxt = bus.len;
          if (bus.len == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt   = ISSUE;
            ra_en_nxt   = 1'b1;
            ra_addr_nxt = '0;
            cnt_nxt     = CNT_ONE;
          end
        end
      end
      ISSUE: begin
        if (cnt == len_q) begin
          state_nxt = DRAIN;
        end else begin
          ra_en_nxt   = 1'b1;
          ra_addr_nxt = cnt[ADDR_W-1:0];
          cnt_nxt     = cnt + CNT_ONE;
        end
      end
      // v1 low means the last write is now in stage 2, so DONE follows it.
      DRAIN:   if (!v1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill_c) begin
      state_nxt = IDLE;
      ra_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      ra_en   <= 1'b0;
      ra_addr <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      a1      <= '0;
      a2      <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gnt_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_q   <= len_nxt;
      cnt     <= cnt_nxt;
      ra_en   <= ra_en_nxt;
      ra_addr <= ra_addr_nxt;
      v1      <= ra_en & ~kill_c;
      v2      <= v1 & ~kill_c;
      a1      <= ra_addr;
      a2      <= a1;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      gnt_q   <= (state_nxt == IDLE);
      ovf_q   <= ovf_nxt;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.host_gnt = gnt_q;
  assign bus.ra_en    = ra_en;
  assign bus.ra_addr  = ra_addr;
  assign bus.rb_en    = ra_en;
  assign bus.rb_addr  = ra_addr;
  assign bus.ws_en    = v2;
  assign bus.ws_addr  = a2;
  assign bus.ws_din   = sum;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_vadd_seq.sv
// Randomized bench for vadd_seq with behavioural RAMs and an arithmetic reference model.
module tb_vadd_seq;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;
  localparam longint      MAXV  = (longint'(1) << (DW - 1)) - 1;
  localparam longint      MINV  = -(longint'(1) << (DW - 1));

  typedef struct {
    int unsigned   addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vadd_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vadd_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  wr_t wq[$];
  int n_rd = 0, n_done = 0, n_busy = 0, n_rb_bad = 0;
  int n_vec = 0, n_err = 0;

  // Source RAMs: one-cycle read latency
  always @(posedge clk) begin
    if (bus.ra_en) bus.ra_dout <= mem_a[bus.ra_addr];
    if (bus.rb_en) bus.rb_dout <= mem_b[bus.rb_addr];
  end

  // RAM S write log plus activity counters, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.ws_en) wq.push_back('{addr: 32'(bus.ws_addr), data: bus.ws_din});
    if (bus.ra_en) n_rd++;
    if (bus.done) n_done++;
    if (bus.busy) n_busy++;
    if (bus.rb_en !== bus.ra_en || bus.rb_addr !== bus.ra_addr) n_rb_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] s, output bit o);
    longint t;
    t = longint'($signed(a)) + longint'($signed(b));
    o = (t > MAXV) || (t < MINV);
    s = t[DW-1:0];
`ifdef VADD_SAT_EN
    if (t > MAXV) s = DW'(MAXV);
    if (t < MINV) s = DW'(MINV);
`endif
  endfunction

  // mode 0: uniform, 1: large same-sign pairs mixed in, 2: small positives
  task automatic fill(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      mem_a[i] = $urandom();
      mem_b[i] = $urandom();
      if (mode == 1 && $urandom_range(0, 1) == 1) begin
        mem_a[i][DW-1:DW-2] = $urandom_range(0, 1) == 1 ? 2'b10 : 2'b01;
        mem_b[i][DW-1:DW-2] = mem_a[i][DW-1:DW-2];
      end
      if (mode == 2) begin
        mem_a[i] = DW'($urandom_range(0, 1000));
        mem_b[i] = DW'($urandom_range(0, 1000));
      end
    end
  endtask

  // abort_at: -1 none, 0 together with start, k>0 during run cycle k
  task automatic run(input string tag, input int n, input int abort_at, input int restart_at);
    int q0, rd0, dn0, bz0, done_at, exp_done, nw, nr;
    bit exp_ovf, o;
    logic [DW-1:0] es;
    q0 = wq.size(); rd0 = n_rd; dn0 = n_done; bz0 = n_busy; done_at = -1;
    exp_done = (n == 0) ? 1 : n + 3;
    bus.start = 1'b1;
    bus.len   = (AW+1)'(n);
    bus.abort = (abort_at == 0);
    for (int cyc = 1; cyc <= exp_done + 10; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (bus.done && done_at < 0) done_at = cyc;
      if (cyc == 1) chk({tag, "_busy1"}, bus.busy, 1);
      if (abort_at > 0 && cyc == abort_at + 1) chk({tag, "_gnt"}, bus.host_gnt, 1);
      if (cyc == abort_at) bus.abort = 1'b1;
      if (cyc == restart_at) begin
        bus.start = 1'b1;
        bus.len   = (AW+1)'(2);
      end
    end
    if (abort_at > 0) begin nr = abort_at; nw = abort_at - 2; end
    else begin nr = n; nw = n; end
    chk({tag, "_done_at"}, done_at, abort_at > 0 ? -1 : exp_done);
    chk({tag, "_dones"}, n_done - dn0, abort_at > 0 ? 0 : 1);
    chk({tag, "_reads"}, n_rd - rd0, nr);
    chk({tag, "_busy_cyc"}, n_busy - bz0, abort_at > 0 ? abort_at : exp_done);
    chk({tag, "_writes"}, wq.size() - q0, nw);
    exp_ovf = 1'b0;
    for (int i = 0; i < nw; i++) begin
      ref_add(mem_a[i], mem_b[i], es, o);
      exp_ovf |= o;
      if (q0 + i < wq.size()) begin
        chk({tag, "_waddr"}, wq[q0+i].addr, i);
        chk({tag, "_wdata"}, wq[q0+i].data, es);
      end
    end
    chk({tag, "_ovf"}, bus.ovf, exp_ovf);
    chk({tag, "_idle_gnt"}, bus.host_gnt, 1);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sat_exp;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_gnt", bus.host_gnt, 1);
    chk("rst_ra_en", bus.ra_en, 0);
    chk("rst_ws_en", bus.ws_en, 0);
    chk("rst_ra_addr", bus.ra_addr, 0);
    chk("rst_ws_din", bus.ws_din, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(10 * (i + 1));
    end
    run("vec4", 4, -1, -1);
    chk("vec4_s3", wq[$].data, 44);

    run("len0", 0, -1, -1);

    mem_a[0] = 32'h7FFF_FFFF;
    mem_b[0] = 32'h0000_0001;
    run("ovf1", 1, -1, -1);
`ifdef VADD_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0000;
`endif
    chk("ovf1_s0", wq[$].data, sat_exp);

    fill(9, 2);
    run("ovf_clr", 9, -1, -1);

    for (int k = 0; k < 6; k++) begin
      int lens [6] = '{1, 2, 3, 5, 17, 64};
      fill(lens[k], k % 2);
      run($sformatf("rand%0d", lens[k]), lens[k], -1, -1);
    end

    fill(DEPTH, 1);
    run("full", DEPTH, -1, -1);

    fill(8, 0);
    run("abort", 8, 3, -1);

    fill(5, 1);
    run("start_abort", 5, 0, -1);

    fill(6, 1);
    run("restart", 6, -1, 2);

    // Asynchronous reset in the middle of a run
    fill(20, 0);
    bus.start = 1'b1;
    bus.len   = (AW+1)'(20);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ra_en", bus.ra_en, 0);
    chk("arst_ws_en", bus.ws_en, 0);
    chk("arst_gnt", bus.host_gnt, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fill(7, 1);
    run("post_rst", 7, -1, -1);

    chk("rb_mirror", n_rb_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
